// File: rtl/sparce_skip_ctrl.sv
// sparce_skip_ctrl
// Turns SparCE PSRU skip decisions into fetch redirects. When a skip is accepted,
// the block raises one registered redirect request and holds it until fetch
// acknowledges it, a pipeline flush cancels it, or a timeout abandons it. An
// acknowledged redirect is followed by a cooldown in which new skips are ignored.
// The block also keeps saturating skip statistics for the SparCE CSRs.
//
// Ports
//   CLK, RST          clock; synchronous active-high reset
//   skip_in           PSRU skip decision, valid in the same cycle
//   target_in         PSRU skip target PC
//   insts_to_skip_in  number of instructions this skip removes
//   enable            SparCE control-flow enable; gates new acceptance only
//   pipe_flush        higher-priority pipeline redirect
//   redirect_ack      fetch accepted redirect_pc in this cycle
//   redirect_req      registered redirect request to fetch
//   redirect_pc       redirect target; held stable while redirect_req is high
//   busy              controller is not idle
//   align_err         one-cycle pulse: a misaligned target was rejected
//   timeout_err       one-cycle pulse: a request was abandoned without an ack
//   clr_stats         clears both statistics counters
//   skip_count        number of acknowledged skips (saturating)
//   insts_skipped     total instructions skipped by acknowledged skips (saturating)
module sparce_skip_ctrl #(
   parameter int INSTS_W     = 5,
   parameter int CNT_W       = 32,
   parameter int HOLD_CYCLES = 2,
   parameter int TIMEOUT     = 15
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               skip_in,
   input  logic [31:0]        target_in,
   input  logic [INSTS_W-1:0] insts_to_skip_in,
   input  logic               enable,
   input  logic               pipe_flush,
   input  logic               redirect_ack,
   output logic               redirect_req,
   output logic [31:0]        redirect_pc,
   output logic               busy,
   output logic               align_err,
   output logic               timeout_err,
   input  logic               clr_stats,
   output logic [CNT_W-1:0]   skip_count,
   output logic [CNT_W-1:0]   insts_skipped
);

   // The shared timer counts REQ wait cycles up and HOLD cooldown cycles down.
   localparam int TMR_MAX = (TIMEOUT > HOLD_CYCLES) ? TIMEOUT : HOLD_CYCLES;
   localparam int TMR_W   = (TMR_MAX < 2) ? 1 : $clog2(TMR_MAX + 1);

   typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

   state_t             state_q, state_d;
   logic [TMR_W-1:0]   tmr_q, tmr_d;
   logic [INSTS_W-1:0] size_q;
   logic               req_d, align_d, tout_d;
   logic               load_pc, stats_inc;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] acc);
      return (&acc) ? acc : acc + CNT_W'(1);
   endfunction

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0]   acc,
                                                input logic [INSTS_W-1:0] add);
      logic [CNT_W:0] sum;
      sum = {1'b0, acc} + {{(CNT_W + 1 - INSTS_W){1'b0}}, add};
      return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
   endfunction

   always_comb begin
      state_d   = state_q;
      tmr_d     = tmr_q;
      req_d     = 1'b0;
      align_d   = 1'b0;
      tout_d    = 1'b0;
      load_pc   = 1'b0;
      stats_inc = 1'b0;
      case (state_q)
         IDLE: begin
            if (skip_in && enable && !pipe_flush) begin
               // Only word-aligned targets are legal redirect destinations.
               if (target_in[1:0] != 2'b00) begin
                  align_d = 1'b1;
               end else begin
                  load_pc = 1'b1;
                  tmr_d   = '0;
                  req_d   = 1'b1;
                  state_d = REQ;
               end
            end
         end
         REQ: begin
            if (pipe_flush) begin
               state_d = IDLE;
            end else if (redirect_ack) begin
               stats_inc = 1'b1;
               if (HOLD_CYCLES == 0) begin
                  state_d = IDLE;
               end else begin
                  tmr_d   = TMR_W'(HOLD_CYCLES);
                  state_d = HOLD;
               end
            end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
               // Timer counts from 0, so the request stays up exactly TIMEOUT cycles.
               tout_d  = 1'b1;
               state_d = IDLE;
            end else begin
               tmr_d = tmr_q + TMR_W'(1);
               req_d = 1'b1;
            end
         end
         HOLD: begin
            tmr_d = tmr_q - TMR_W'(1);
            if (tmr_q <= TMR_W'(1)) begin
               tmr_d   = '0;
               state_d = IDLE;
            end
         end
         default: begin
            tmr_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q       <= IDLE;
         tmr_q         <= '0;
         size_q        <= '0;
         redirect_req  <= 1'b0;
         redirect_pc   <= '0;
         align_err     <= 1'b0;
         timeout_err   <= 1'b0;
         skip_count    <= '0;
         insts_skipped <= '0;
      end else begin
         state_q      <= state_d;
         tmr_q        <= tmr_d;
         redirect_req <= req_d;
         align_err    <= align_d;
         timeout_err  <= tout_d;
         if (load_pc) begin
            redirect_pc <= target_in;
            size_q      <= insts_to_skip_in;
         end
         // A clear in the same cycle as an increment wins.
         if (clr_stats) begin
            skip_count    <= '0;
            insts_skipped <= '0;
         end else if (stats_inc) begin
            skip_count    <= sat_inc(skip_count);
            insts_skipped <= sat_add(insts_skipped, size_q);
         end
      end
   end

   assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_sparce_skip_ctrl.sv
module tb_sparce_skip_ctrl;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        skip_in = 1'b0, enable = 1'b0, pipe_flush = 1'b0, redirect_ack = 1'b0, clr_stats = 1'b0;
   logic [31:0] target_in = '0;
   logic [4:0]  insts_to_skip_in = '0;
   logic        redirect_req, busy, align_err, timeout_err;
   logic [31:0] redirect_pc, skip_count, insts_skipped;

   // Narrow instance: 3-bit counters reach saturation quickly; no cooldown.
   logic        s_skip = 1'b0, s_ack = 1'b0, s_clr = 1'b0;
   logic [31:0] s_target = '0;
   logic [2:0]  s_insts = '0;
   logic        s_req, s_busy, s_align, s_tout;
   logic [31:0] s_pc;
   logic [2:0]  s_count, s_iskip;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   always #5 CLK = ~CLK;

   sparce_skip_ctrl dut (
      .CLK(CLK), .RST(RST), .skip_in(skip_in), .target_in(target_in),
      .insts_to_skip_in(insts_to_skip_in), .enable(enable), .pipe_flush(pipe_flush),
      .redirect_ack(redirect_ack), .redirect_req(redirect_req), .redirect_pc(redirect_pc),
      .busy(busy), .align_err(align_err), .timeout_err(timeout_err), .clr_stats(clr_stats),
      .skip_count(skip_count), .insts_skipped(insts_skipped)
   );

   sparce_skip_ctrl #(.INSTS_W(3), .CNT_W(3), .HOLD_CYCLES(0), .TIMEOUT(4)) u_sat (
      .CLK(CLK), .RST(RST), .skip_in(s_skip), .target_in(s_target),
      .insts_to_skip_in(s_insts), .enable(1'b1), .pipe_flush(1'b0),
      .redirect_ack(s_ack), .redirect_req(s_req), .redirect_pc(s_pc),
      .busy(s_busy), .align_err(s_align), .timeout_err(s_tout), .clr_stats(s_clr),
      .skip_count(s_count), .insts_skipped(s_iskip)
   );

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      step();
      step();
      RST = 1'b0;
      enable = 1'b1;
      chk_cnt++; if (redirect_req !== 1'b0) $display("FAIL reset_req: got %b want 0", redirect_req); else pass_cnt++;
      chk_cnt++; if (redirect_pc !== 32'h0) $display("FAIL reset_pc: got %h want 0", redirect_pc); else pass_cnt++;
      chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
      chk_cnt++; if ({align_err, timeout_err} !== 2'b00) $display("FAIL reset_err: got %b want 00", {align_err, timeout_err}); else pass_cnt++;
      chk_cnt++; if (skip_count !== 32'd0 || insts_skipped !== 32'd0) $display("FAIL reset_stats: got %0d/%0d want 0/0", skip_count, insts_skipped); else pass_cnt++;
   endtask

   task automatic test_basic_skip();
      skip_in = 1'b1; target_in = 32'h100; insts_to_skip_in = 5'd3;
      step();
      skip_in = 1'b0;
      chk_cnt++; if (redirect_req !== 1'b1) $display("FAIL basic_req1: got %b want 1", redirect_req); else pass_cnt++;
      chk_cnt++; if (redirect_pc !== 32'h100) $display("FAIL basic_pc: got %h want 100", redirect_pc); else pass_cnt++;
      step();
      chk_cnt++; if (redirect_req !== 1'b1) $display("FAIL basic_req2: got %b want 1", redirect_req); else pass_cnt++;
      redirect_ack = 1'b1;
      step();
      redirect_ack = 1'b0;
      chk_cnt++; if (redirect_req !== 1'b0) $display("FAIL basic_req_drop: got %b want 0", redirect_req); else pass_cnt++;
      chk_cnt++; if (skip_count !== 32'd1 || insts_skipped !== 32'd3) $display("FAIL basic_stats: got %0d/%0d want 1/3", skip_count, insts_skipped); else pass_cnt++;
      chk_cnt++; if (busy !== 1'b1) $display("FAIL basic_hold1: got %b want 1", busy); else pass_cnt++;
      step();
      chk_cnt++; if (busy !== 1'b1) $display("FAIL basic_hold2: got %b want 1", busy); else pass_cnt++;
      step();
      chk_cnt++; if (busy !== 1'b0) $display("FAIL basic_idle: got %b want 0", busy); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      skip_in = 1'b1; target_in = 32'h200; insts_to_skip_in = 5'd4;
      step();
      chk_cnt++; if (redirect_req !== 1'b1) $display("FAIL b2b_req1: got %b want 1", redirect_req); else pass_cnt++;
      redirect_ack = 1'b1;
      step();
      redirect_ack = 1'b0;
      chk_cnt++; if (redirect_req !== 1'b0 || skip_count !== 32'd2 || insts_skipped !== 32'd7)
         $display("FAIL b2b_ack1: got req=%b %0d/%0d want req=0 2/7", redirect_req, skip_count, insts_skipped); else pass_cnt++;
      step();
      chk_cnt++; if (redirect_req !== 1'b0) $display("FAIL b2b_hold_a: got %b want 0", redirect_req); else pass_cnt++;
      step();
      chk_cnt++; if (redirect_req !== 1'b0) $display("FAIL b2b_hold_b: got %b want 0", redirect_req); else pass_cnt++;
      step();
      chk_cnt++; if (redirect_req !== 1'b1 || redirect_pc !== 32'h200) $display("FAIL b2b_req2: got req=%b pc=%h want 1/200", redirect_req, redirect_pc); else pass_cnt++;
      skip_in = 1'b0;
      redirect_ack = 1'b1;
      step();
      redirect_ack = 1'b0;
      chk_cnt++; if (skip_count !== 32'd3 || insts_skipped !== 32'd11) $display("FAIL b2b_stats: got %0d/%0d want 3/11", skip_count, insts_skipped); else pass_cnt++;
      step();
      step();
   endtask

   task automatic test_flush_vs_ack();
      skip_in = 1'b1; target_in = 32'h300; insts_to_skip_in = 5'd5;
      step();
      skip_in = 1'b0;
      redirect_ack = 1'b1; pipe_flush = 1'b1;
      step();
      redirect_ack = 1'b0; pipe_flush = 1'b0;
      chk_cnt++; if (redirect_req !== 1'b0 || busy !== 1'b0) $display("FAIL flush_state: got req=%b busy=%b want 0/0", redirect_req, busy); else pass_cnt++;
      chk_cnt++; if (skip_count !== 32'd3 || insts_skipped !== 32'd11) $display("FAIL flush_stats: got %0d/%0d want 3/11", skip_count, insts_skipped); else pass_cnt++;
      chk_cnt++; if ({align_err, timeout_err} !== 2'b00) $display("FAIL flush_err: got %b want 00", {align_err, timeout_err}); else pass_cnt++;
   endtask

   task automatic test_timeout();
      int   n = 0;
      logic pc_ok = 1'b1;
      skip_in = 1'b1; target_in = 32'h400; insts_to_skip_in = 5'd2;
      step();
      skip_in = 1'b0;
      while (redirect_req === 1'b1 && n < 40) begin
         if (redirect_pc !== 32'h400) pc_ok = 1'b0;
         n++;
         step();
      end
      chk_cnt++; if (n != 15) $display("FAIL timeout_len: got %0d cycles want 15", n); else pass_cnt++;
      chk_cnt++; if (pc_ok !== 1'b1) $display("FAIL timeout_pc_stable: got %b want 1", pc_ok); else pass_cnt++;
      chk_cnt++; if (timeout_err !== 1'b1 || busy !== 1'b0) $display("FAIL timeout_pulse: got err=%b busy=%b want 1/0", timeout_err, busy); else pass_cnt++;
      step();
      chk_cnt++; if (timeout_err !== 1'b0) $display("FAIL timeout_pulse_end: got %b want 0", timeout_err); else pass_cnt++;
      chk_cnt++; if (skip_count !== 32'd3 || insts_skipped !== 32'd11) $display("FAIL timeout_stats: got %0d/%0d want 3/11", skip_count, insts_skipped); else pass_cnt++;
   endtask

   task automatic test_align_enable();
      skip_in = 1'b1; target_in = 32'h102; insts_to_skip_in = 5'd1;
      step();
      skip_in = 1'b0;
      chk_cnt++; if (align_err !== 1'b1 || redirect_req !== 1'b0 || busy !== 1'b0)
         $display("FAIL align_pulse: got err=%b req=%b busy=%b want 1/0/0", align_err, redirect_req, busy); else pass_cnt++;
      step();
      chk_cnt++; if (align_err !== 1'b0) $display("FAIL align_pulse_end: got %b want 0", align_err); else pass_cnt++;
      enable = 1'b0; skip_in = 1'b1; target_in = 32'h500;
      step();
      chk_cnt++; if (redirect_req !== 1'b0 || busy !== 1'b0) $display("FAIL disabled_skip: got req=%b busy=%b want 0/0", redirect_req, busy); else pass_cnt++;
      skip_in = 1'b0; enable = 1'b1;
      redirect_ack = 1'b1;
      step();
      redirect_ack = 1'b0;
      chk_cnt++; if (skip_count !== 32'd3 || busy !== 1'b0) $display("FAIL idle_ack: got cnt=%0d busy=%b want 3/0", skip_count, busy); else pass_cnt++;
   endtask

   task automatic test_enable_mid_req();
      skip_in = 1'b1; target_in = 32'h600; insts_to_skip_in = 5'd1;
      step();
      skip_in = 1'b0; enable = 1'b0;
      step();
      chk_cnt++; if (redirect_req !== 1'b1) $display("FAIL en_mid_req: got %b want 1", redirect_req); else pass_cnt++;
      redirect_ack = 1'b1;
      step();
      redirect_ack = 1'b0; enable = 1'b1;
      chk_cnt++; if (skip_count !== 32'd4 || insts_skipped !== 32'd12) $display("FAIL en_mid_stats: got %0d/%0d want 4/12", skip_count, insts_skipped); else pass_cnt++;
      step();
      step();
   endtask

   task automatic test_reset_mid_req();
      skip_in = 1'b1; target_in = 32'h800; insts_to_skip_in = 5'd2;
      step();
      skip_in = 1'b0;
      RST = 1'b1;
      step();
      RST = 1'b0;
      chk_cnt++; if (redirect_req !== 1'b0 || redirect_pc !== 32'h0 || busy !== 1'b0)
         $display("FAIL rst_mid: got req=%b pc=%h busy=%b want 0/0/0", redirect_req, redirect_pc, busy); else pass_cnt++;
      chk_cnt++; if (skip_count !== 32'd0 || insts_skipped !== 32'd0) $display("FAIL rst_mid_stats: got %0d/%0d want 0/0", skip_count, insts_skipped); else pass_cnt++;
   endtask

   task automatic test_clr_with_ack();
      skip_in = 1'b1; target_in = 32'h700; insts_to_skip_in = 5'd3;
      step();
      skip_in = 1'b0;
      redirect_ack = 1'b1; clr_stats = 1'b1;
      step();
      redirect_ack = 1'b0; clr_stats = 1'b0;
      chk_cnt++; if (skip_count !== 32'd0 || insts_skipped !== 32'd0) $display("FAIL clr_ack: got %0d/%0d want 0/0", skip_count, insts_skipped); else pass_cnt++;
      step();
      step();
   endtask

   task automatic sat_skip(input logic [2:0] size, input logic clr);
      s_skip = 1'b1; s_target = 32'h10; s_insts = size;
      step();
      s_skip = 1'b0;
      s_ack = 1'b1; s_clr = clr;
      step();
      s_ack = 1'b0; s_clr = 1'b0;
   endtask

   task automatic test_saturation();
      sat_skip(3'd3, 1'b0);
      chk_cnt++; if (s_count !== 3'd1 || s_iskip !== 3'd3 || s_busy !== 1'b0)
         $display("FAIL sat_first: got %0d/%0d busy=%b want 1/3/0", s_count, s_iskip, s_busy); else pass_cnt++;
      sat_skip(3'd6, 1'b0);
      chk_cnt++; if (s_iskip !== 3'd7) $display("FAIL sat_insts_clamp: got %0d want 7", s_iskip); else pass_cnt++;
      for (int i = 0; i < 6; i++) sat_skip(3'd1, 1'b0);
      chk_cnt++; if (s_count !== 3'd7 || s_iskip !== 3'd7) $display("FAIL sat_all_ones: got %0d/%0d want 7/7", s_count, s_iskip); else pass_cnt++;
      sat_skip(3'd2, 1'b1);
      chk_cnt++; if (s_count !== 3'd0 || s_iskip !== 3'd0) $display("FAIL sat_clr_ack: got %0d/%0d want 0/0", s_count, s_iskip); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_basic_skip();
      test_back_to_back();
      test_flush_vs_ack();
      test_timeout();
      test_align_enable();
      test_enable_mid_req();
      test_reset_mid_req();
      test_clr_with_ack();
      test_saturation();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", pass_cnt, chk_cnt);
      $fatal(1);
   end

endmodule
